multicycle_control_fsm: RTL and testbench

- Main sequencing controller for the multicycle RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath's register-enable and mux-select lines.
- Takes the 7-bit opcode from the instruction register, the branch-compare result and the memory ready handshake.
- Runs in parallel with the immediate decoder, which remains the sole source of immediate-format selection.

---
 rtl/multicycle_control_fsm_if.sv | 37 +++
 rtl/multicycle_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
// Carries the decode/handshake inputs, the enable/select lines and the status outputs.
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STATE_W = 4
);
  logic [6:0]         opcode;
  logic               branch_taken;
  logic               mem_ready;
  logic               pc_write;
  logic               old_pc_write;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               addr_sel;
  logic               reg_write;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic [1:0]         wb_sel;
  logic               illegal;
  logic [CNT_W-1:0]   instret;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output pc_write, old_pc_write, ir_write, mem_read, mem_write, addr_sel, reg_write,
    output alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, illegal, instret, state_dbg
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  pc_write, old_pc_write, ir_write, mem_read, mem_write, addr_sel, reg_write,
    input  alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, illegal, instret, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath control lines.
module multicycle_control_fsm #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned STATE_W = 4
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master ctrl_io
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StLui, StAuipc, StAluWb, StMemAddr,
    StMemRd, StMemWb, StMemWr, StBranch, StJal, StJalr, StTrap
  } state_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpFence = 7'b0001111;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    ctrl_io.pc_write     = 1'b0;
    ctrl_io.old_pc_write = 1'b0;
    ctrl_io.ir_write     = 1'b0;
    ctrl_io.mem_read     = 1'b0;
    ctrl_io.mem_write    = 1'b0;
    ctrl_io.addr_sel     = 1'b0;
    ctrl_io.reg_write    = 1'b0;
    ctrl_io.alu_src_a    = 2'd0;
    ctrl_io.alu_src_b    = 2'd0;
    ctrl_io.alu_op       = 2'd0;
    ctrl_io.pc_src       = 2'd0;
    ctrl_io.wb_sel       = 2'd0;
    // Reset forces every control line low, whatever state is held.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          ctrl_io.mem_read  = 1'b1;
          ctrl_io.alu_src_b = 2'd2;
          if (ctrl_io.mem_ready) begin
            ctrl_io.ir_write     = 1'b1;
            ctrl_io.pc_write     = 1'b1;
            ctrl_io.old_pc_write = 1'b1;
            state_d              = StDecode;
          end
        end
        StDecode: begin
          ctrl_io.alu_src_a = 2'd2;
          ctrl_io.alu_src_b = 2'd1;
          case (ctrl_io.opcode)
            OpR:             state_d = StExecR;
            OpI:             state_d = StExecI;
            OpLoad, OpStore: state_d = StMemAddr;
            OpBr:            state_d = StBranch;
            OpJal:           state_d = StJal;
            OpJalr:          state_d = StJalr;
            OpLui:           state_d = StLui;
            OpAuipc:         state_d = StAuipc;
            OpFence:         state_d = StFetch;
            default:         state_d = StTrap;
          endcase
        end
        StExecR: begin
          ctrl_io.alu_src_a = 2'd1;
          ctrl_io.alu_op    = 2'd2;
          state_d           = StAluWb;
        end
        StExecI: begin
          ctrl_io.alu_src_a = 2'd1;
          ctrl_io.alu_src_b = 2'd1;
          ctrl_io.alu_op    = 2'd3;
          state_d           = StAluWb;
        end
        StLui: begin
          ctrl_io.alu_src_a = 2'd3;
          ctrl_io.alu_src_b = 2'd1;
          state_d           = StAluWb;
        end
        StAuipc: begin
          ctrl_io.alu_src_a = 2'd2;
          ctrl_io.alu_src_b = 2'd1;
          state_d           = StAluWb;
        end
        StAluWb: begin
          ctrl_io.reg_write = 1'b1;
          state_d           = StFetch;
        end
        StMemAddr: begin
          ctrl_io.alu_src_a = 2'd1;
          ctrl_io.alu_src_b = 2'd1;
          state_d           = (ctrl_io.opcode == OpLoad) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          ctrl_io.mem_read = 1'b1;
          ctrl_io.addr_sel = 1'b1;
          if (ctrl_io.mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          ctrl_io.reg_write = 1'b1;
          ctrl_io.wb_sel    = 2'd1;
          state_d           = StFetch;
        end
        StMemWr: begin
          ctrl_io.mem_write = 1'b1;
          ctrl_io.addr_sel  = 1'b1;
          if (ctrl_io.mem_ready) state_d = StFetch;
        end
        StBranch: begin
          ctrl_io.alu_src_a = 2'd1;
          ctrl_io.alu_op    = 2'd1;
          ctrl_io.pc_src    = 2'd1;
          ctrl_io.pc_write  = ctrl_io.branch_taken;
          state_d           = StFetch;
        end
        StJal: begin
          ctrl_io.pc_write  = 1'b1;
          ctrl_io.pc_src    = 2'd1;
          ctrl_io.reg_write = 1'b1;
          ctrl_io.wb_sel    = 2'd2;
          state_d           = StFetch;
        end
        StJalr: begin
          ctrl_io.alu_src_a = 2'd1;
          ctrl_io.alu_src_b = 2'd1;
          ctrl_io.pc_write  = 1'b1;
          ctrl_io.pc_src    = 2'd2;
          ctrl_io.reg_write = 1'b1;
          ctrl_io.wb_sel    = 2'd2;
          state_d           = StFetch;
        end
        StTrap:  state_d = StTrap;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == StTrap);
    instret_d = instret_q;
    if (state_q != StFetch && state_d == StFetch) instret_d = instret_q + CNT_W'(1);
  end

  assign ctrl_io.illegal   = illegal_q;
  assign ctrl_io.instret   = instret_q;
  assign ctrl_io.state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks instruction classes cycle by
// cycle and compares the packed control vector against hand-derived signatures.
module tb_multicycle_control_fsm;

  // Packed order: pw opw irw mr mw as rw | a b op pc_src wb
  localparam logic [16:0] S_ZERO    = 17'b0000000_00_00_00_00_00;
  localparam logic [16:0] S_FETCH_W = 17'b0001000_00_10_00_00_00;
  localparam logic [16:0] S_FETCH_R = 17'b1111000_00_10_00_00_00;
  localparam logic [16:0] S_DECODE  = 17'b0000000_10_01_00_00_00;
  localparam logic [16:0] S_EXEC_R  = 17'b0000000_01_00_10_00_00;
  localparam logic [16:0] S_ALU_WB  = 17'b0000001_00_00_00_00_00;
  localparam logic [16:0] S_MADDR   = 17'b0000000_01_01_00_00_00;
  localparam logic [16:0] S_MEM_RD  = 17'b0001010_00_00_00_00_00;
  localparam logic [16:0] S_MEM_WB  = 17'b0000001_00_00_00_00_01;
  localparam logic [16:0] S_MEM_WR  = 17'b0000110_00_00_00_00_00;
  localparam logic [16:0] S_BR_T    = 17'b1000000_01_00_01_01_00;
  localparam logic [16:0] S_BR_N    = 17'b0000000_01_00_01_01_00;
  localparam logic [16:0] S_JAL     = 17'b1000001_00_00_00_01_10;
  localparam logic [16:0] S_JALR    = 17'b1000001_01_01_00_10_10;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int unsigned exp_instret;

  multicycle_control_fsm_if #(.CNT_W(32), .STATE_W(4)) bus ();

  multicycle_control_fsm #(.CNT_W(32), .STATE_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_io (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ctrl();
    return {bus.pc_write, bus.old_pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
            bus.addr_sel, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_src, bus.wb_sel};
  endfunction

  // Advance one clock and leave time for new inputs to settle before sampling.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 7'h33; bus.branch_taken = 1'b0;
    next_cycle(); next_cycle();
    #1;
    total++;
    if (ctrl() !== S_ZERO) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", ctrl(), S_ZERO);
    end
    total++;
    if (bus.illegal !== 1'b0 || bus.instret !== 32'd0) begin
      bad++; $display("FAIL reset_regs got illegal=%b instret=%0d want 0/0", bus.illegal, bus.instret);
    end
    reset = 1'b0; bus.mem_ready = 1'b0;
    next_cycle(); #1;
    total++;
    if (ctrl() !== S_FETCH_W) begin
      bad++; $display("FAIL reset_fetch got=%b want=%b", ctrl(), S_FETCH_W);
    end
    exp_instret = 0;
  endtask

  task automatic test_add();
    logic [16:0] exp_seq [4];
    exp_seq = '{S_FETCH_R, S_DECODE, S_EXEC_R, S_ALU_WB};
    bus.opcode = 7'b0110011; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (ctrl() !== exp_seq[i]) begin
        bad++; $display("FAIL add_cycle%0d got=%b want=%b", i, ctrl(), exp_seq[i]);
      end
      if (i == 2) begin
        total++;
        if (bus.instret !== exp_instret) begin
          bad++; $display("FAIL add_instret_before got=%0d want=%0d", bus.instret, exp_instret);
        end
      end
      next_cycle();
    end
    exp_instret++;
    bus.mem_ready = 1'b0; #1;
    total++;
    if (ctrl() !== S_FETCH_W || bus.instret !== exp_instret) begin
      bad++; $display("FAIL add_retire got=%b instret=%0d want=%b instret=%0d",
                      ctrl(), bus.instret, S_FETCH_W, exp_instret);
    end
  endtask

  task automatic test_lw();
    logic [16:0] exp_seq [10];
    logic        rdy_seq [10];
    int          irw_cnt;
    int          wb_cnt;
    exp_seq = '{S_FETCH_W, S_FETCH_W, S_FETCH_W, S_FETCH_R, S_DECODE, S_MADDR,
                S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};
    rdy_seq = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
    irw_cnt = 0; wb_cnt = 0;
    bus.opcode = 7'b0000011;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = rdy_seq[i]; #1;
      total++;
      if (ctrl() !== exp_seq[i]) begin
        bad++; $display("FAIL lw_cycle%0d got=%b want=%b", i, ctrl(), exp_seq[i]);
      end
      if (bus.ir_write) irw_cnt++;
      if (bus.reg_write && bus.wb_sel == 2'd1) wb_cnt++;
      next_cycle();
    end
    exp_instret++;
    total++;
    if (irw_cnt !== 1 || wb_cnt !== 1) begin
      bad++; $display("FAIL lw_pulses got irw=%0d wb=%0d want 1/1", irw_cnt, wb_cnt);
    end
    bus.mem_ready = 1'b0; #1;
    total++;
    if (ctrl() !== S_FETCH_W || bus.instret !== exp_instret) begin
      bad++; $display("FAIL lw_retire got=%b instret=%0d want=%b instret=%0d",
                      ctrl(), bus.instret, S_FETCH_W, exp_instret);
    end
  endtask

  task automatic test_branch();
    logic [16:0] exp_br;
    for (int t = 1; t >= 0; t--) begin
      exp_br = (t == 1) ? S_BR_T : S_BR_N;
      bus.opcode = 7'b1100011; bus.mem_ready = 1'b1; bus.branch_taken = t[0];
      next_cycle();
      bus.mem_ready = 1'b1; #1;
      total++;
      if (ctrl() !== S_DECODE) begin
        bad++; $display("FAIL br%0d_decode got=%b want=%b", t, ctrl(), S_DECODE);
      end
      next_cycle(); #1;
      total++;
      if (ctrl() !== exp_br) begin
        bad++; $display("FAIL br%0d_branch got=%b want=%b", t, ctrl(), exp_br);
      end
      next_cycle();
      exp_instret++;
      bus.mem_ready = 1'b0; bus.branch_taken = 1'b0; #1;
      total++;
      if (ctrl() !== S_FETCH_W || bus.instret !== exp_instret) begin
        bad++; $display("FAIL br%0d_retire got=%b instret=%0d want=%b instret=%0d",
                        t, ctrl(), bus.instret, S_FETCH_W, exp_instret);
      end
    end
  endtask

  task automatic test_jumps();
    logic [6:0]  ops [2];
    logic [16:0] exps [2];
    ops = '{7'b1100111, 7'b1101111};
    exps = '{S_JALR, S_JAL};
    for (int j = 0; j < 2; j++) begin
      bus.opcode = ops[j]; bus.mem_ready = 1'b1;
      next_cycle(); next_cycle();
      bus.mem_ready = 1'b0; #1;
      total++;
      if (ctrl() !== exps[j]) begin
        bad++; $display("FAIL jump%0d got=%b want=%b", j, ctrl(), exps[j]);
      end
      next_cycle();
      exp_instret++;
    end
    // FENCE retires straight from decode.
    bus.opcode = 7'b0001111; bus.mem_ready = 1'b1;
    next_cycle(); next_cycle();
    exp_instret++;
    bus.mem_ready = 1'b0; #1;
    total++;
    if (ctrl() !== S_FETCH_W || bus.instret !== exp_instret) begin
      bad++; $display("FAIL fence_retire got=%b instret=%0d want=%b instret=%0d",
                      ctrl(), bus.instret, S_FETCH_W, exp_instret);
    end
  endtask

  task automatic test_trap();
    int bad_cycles;
    bus.opcode = 7'b1111111; bus.mem_ready = 1'b1;
    next_cycle(); next_cycle();
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0]; bus.branch_taken = i[1]; #1;
      if (ctrl() !== S_ZERO || bus.illegal !== 1'b1 || bus.instret !== exp_instret)
        bad_cycles++;
      next_cycle();
    end
    total++;
    if (bad_cycles != 0) begin
      bad++; $display("FAIL trap_hold got=%0d bad cycles want=0", bad_cycles);
    end
    reset = 1'b1; bus.mem_ready = 1'b1;
    next_cycle();
    reset = 1'b0; bus.mem_ready = 1'b0; #1;
    exp_instret = 0;
    total++;
    if (ctrl() !== S_FETCH_W || bus.illegal !== 1'b0 || bus.instret !== exp_instret) begin
      bad++; $display("FAIL trap_reset got=%b illegal=%b instret=%0d want=%b illegal=0 instret=0",
                      ctrl(), bus.illegal, bus.instret, S_FETCH_W);
    end
  endtask

  task automatic test_sw_reset();
    bus.opcode = 7'b0100011; bus.mem_ready = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    bus.mem_ready = 1'b0; #1;
    total++;
    if (ctrl() !== S_MEM_WR) begin
      bad++; $display("FAIL sw_wait got=%b want=%b", ctrl(), S_MEM_WR);
    end
    next_cycle();
    reset = 1'b1; #1;
    total++;
    if (bus.mem_write !== 1'b0 || ctrl() !== S_ZERO) begin
      bad++; $display("FAIL sw_reset_cycle got=%b want=%b", ctrl(), S_ZERO);
    end
    next_cycle();
    reset = 1'b0; #1;
    total++;
    if (ctrl() !== S_FETCH_W || bus.instret !== exp_instret) begin
      bad++; $display("FAIL sw_after_reset got=%b instret=%0d want=%b instret=%0d",
                      ctrl(), bus.instret, S_FETCH_W, exp_instret);
    end
  endtask

  initial begin
    total = 0; bad = 0; exp_instret = 0;
    reset = 1'b1; bus.opcode = 7'd0; bus.branch_taken = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jumps();
    test_trap();
    test_sw_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
